// File: rtl/mem_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rr_arbiter_if
//  Description : Requester and memory-side bus bundle for mem_rr_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 14,
    parameter int WDATA_W = 16,
    parameter int RDATA_W = 8
);
    logic [NUM_REQ-1:0]         cs;
    logic [NUM_REQ-1:0]         read_req;
    logic [NUM_REQ-1:0]         write_req;
    logic [NUM_REQ*ADDR_W-1:0]  addr;
    logic [NUM_REQ*WDATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]         resp;
    logic                       err;
    logic [RDATA_W-1:0]         rdata;
    logic                       mem_re;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic [WDATA_W-1:0]         mem_wdata;
    logic [RDATA_W-1:0]         mem_rdata;
    logic                       mem_resp;
    logic [NUM_REQ-1:0]         grant;

    // Arbiter view
    modport slave (
        input  cs, read_req, write_req, addr, wdata, mem_rdata, mem_resp,
        output resp, err, rdata, mem_re, mem_we, mem_addr, mem_wdata, grant
    );

    // Environment view: requesters plus memory
    modport master (
        output cs, read_req, write_req, addr, wdata, mem_rdata, mem_resp,
        input  resp, err, rdata, mem_re, mem_we, mem_addr, mem_wdata, grant
    );
endinterface

`default_nettype wire

// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rr_arbiter
//  Description : Round-robin arbiter sharing one memory port among NUM_REQ
//                requesters, with a per-access watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 14,
    parameter int WDATA_W = 16,
    parameter int RDATA_W = 8,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    mem_rr_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [PTR_W-1:0]     ptr_q,       ptr_d;
    logic [PTR_W-1:0]     owner_q,     owner_d;
    logic [WD_W-1:0]      wdog_q,      wdog_d;
    logic [NUM_REQ-1:0]   grant_q,     grant_d;
    logic [NUM_REQ-1:0]   resp_q,      resp_d;
    logic                 err_q,       err_d;
    logic [RDATA_W-1:0]   rdata_q,     rdata_d;
    logic                 mem_re_q,    mem_re_d;
    logic                 mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q,  mem_addr_d;
    logic [WDATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic [ADDR_W-1:0]    w_addr_arr  [NUM_REQ];
    logic [WDATA_W-1:0]   w_wdata_arr [NUM_REQ];
    logic [PTR_W-1:0]     w_pick;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic                 w_rd;
    logic                 w_wr;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = bus.wdata[gi*WDATA_W +: WDATA_W];
    end

    // First requesting index at or after the priority pointer, with wrap.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [PTR_W-1:0]   start
    );
        logic [PTR_W-1:0] sel;
        logic [PTR_W-1:0] idx;
        logic             found;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(start) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_pick    = rr_pick(bus.cs, ptr_q);
    assign w_pick_oh = NUM_REQ'(1) << w_pick;
    assign w_rd      = bus.read_req[w_pick];
    assign w_wr      = bus.write_req[w_pick];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        wdog_d      = wdog_q;
        grant_d     = grant_q;
        resp_d      = '0;
        err_d       = 1'b0;
        rdata_d     = '0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (|bus.cs) begin
                    owner_d = w_pick;
                    grant_d = w_pick_oh;
                    wdog_d  = '0;
                    if (w_rd ^ w_wr) begin
                        state_d     = ST_ACCESS;
                        mem_re_d    = w_rd;
                        mem_we_d    = w_wr;
                        mem_addr_d  = w_addr_arr[w_pick];
                        mem_wdata_d = w_wdata_arr[w_pick];
                    end else begin
                        // Both or neither command: reject without touching memory.
                        state_d = ST_RESP;
                        resp_d  = w_pick_oh;
                        err_d   = 1'b1;
                    end
                end
            end

            ST_ACCESS: begin
                if (bus.mem_resp) begin
                    state_d = ST_RESP;
                    resp_d  = grant_q;
                    rdata_d = bus.mem_rdata;
                end else if (wdog_q == WD_LAST) begin
                    state_d = ST_RESP;
                    resp_d  = grant_q;
                    err_d   = 1'b1;
                end else begin
                    wdog_d      = wdog_q + 1'b1;
                    mem_re_d    = mem_re_q;
                    mem_we_d    = mem_we_q;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
                grant_d = '0;
                ptr_d   = (owner_q == PTR_LAST) ? '0 : owner_q + 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            wdog_q      <= '0;
            grant_q     <= '0;
            resp_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            wdog_q      <= wdog_d;
            grant_q     <= grant_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.resp      = resp_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_rr_arbiter
//  Description : Self-checking bench for mem_rr_arbiter (directed + random).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 14;
    localparam int WDATA_W = 16;
    localparam int RDATA_W = 8;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    int   mptr  = 0;

    mem_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .WDATA_W(WDATA_W),
                        .RDATA_W(RDATA_W)) bus ();

    mem_rr_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .WDATA_W(WDATA_W),
                     .RDATA_W(RDATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cs        = '0;
        bus.read_req  = '0;
        bus.write_req = '0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_rdata = '0;
        bus.mem_resp  = 1'b0;
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [ADDR_W-1:0] a, input logic [WDATA_W-1:0] d);
        bus.cs[i]                       = 1'b1;
        bus.read_req[i]                 = rd;
        bus.write_req[i]                = wr;
        bus.addr[i*ADDR_W +: ADDR_W]    = a;
        bus.wdata[i*WDATA_W +: WDATA_W] = d;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        mptr    = 0;
    endtask

    function automatic int pick_model(input logic [NUM_REQ-1:0] req, input int start);
        for (int k = 0; k < NUM_REQ; k++)
            if (req[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        return NUM_REQ'(1) << i;
    endfunction

    task automatic test_reset();
        clear_inputs();
        bus.cs       = '1;
        bus.read_req = '1;
        reset_n      = 1'b0;
        repeat (3) tick();
        total++;
        if (bus.grant !== 4'b0000) begin
            bad++; $display("FAIL reset_grant: got %b want 0000", bus.grant);
        end
        total++;
        if ({bus.resp, bus.err, bus.mem_re, bus.mem_we, bus.rdata} !== 15'd0) begin
            bad++; $display("FAIL reset_outs: got resp=%b err=%b re=%b we=%b rdata=%h want all 0",
                            bus.resp, bus.err, bus.mem_re, bus.mem_we, bus.rdata);
        end
        total++;
        if ({bus.mem_addr, bus.mem_wdata} !== 30'd0) begin
            bad++; $display("FAIL reset_bus: got addr=%h wdata=%h want 0", bus.mem_addr, bus.mem_wdata);
        end
        clear_inputs();
        reset_n = 1'b1;
        tick();
        total++;
        if (bus.grant !== 4'b0000) begin
            bad++; $display("FAIL reset_release: got %b want 0000", bus.grant);
        end
    endtask

    task automatic test_single_read();
        clear_inputs();
        set_req(2, 1'b1, 1'b0, 14'h0123, 16'h0000);
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if ({bus.grant, bus.mem_re, bus.mem_we, bus.mem_addr} !== {4'b0100, 1'b1, 1'b0, 14'h0123}) begin
                bad++; $display("FAIL read_access%0d: got grant=%b re=%b we=%b addr=%h want 0100 1 0 0123",
                                c, bus.grant, bus.mem_re, bus.mem_we, bus.mem_addr);
            end
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 8'hA5;
        tick();
        total++;
        if ({bus.resp, bus.err, bus.rdata, bus.mem_re, bus.grant} !== {4'b0100, 1'b0, 8'hA5, 1'b0, 4'b0100}) begin
            bad++; $display("FAIL read_resp: got resp=%b err=%b rdata=%h re=%b grant=%b want 0100 0 a5 0 0100",
                            bus.resp, bus.err, bus.rdata, bus.mem_re, bus.grant);
        end
        clear_inputs();
        tick();
        total++;
        if ({bus.grant, bus.resp} !== 8'd0) begin
            bad++; $display("FAIL read_idle: got grant=%b resp=%b want 0", bus.grant, bus.resp);
        end
    endtask

    task automatic test_write();
        clear_inputs();
        set_req(1, 1'b0, 1'b1, 14'h02A5, 16'hBEEF);
        tick();
        total++;
        if ({bus.grant, bus.mem_we, bus.mem_re, bus.mem_wdata, bus.mem_addr} !==
            {4'b0010, 1'b1, 1'b0, 16'hBEEF, 14'h02A5}) begin
            bad++; $display("FAIL write_access: got grant=%b we=%b re=%b wdata=%h addr=%h want 0010 1 0 beef 02a5",
                            bus.grant, bus.mem_we, bus.mem_re, bus.mem_wdata, bus.mem_addr);
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 8'h77;
        tick();
        total++;
        if ({bus.resp, bus.err, bus.mem_we} !== {4'b0010, 1'b0, 1'b0}) begin
            bad++; $display("FAIL write_resp: got resp=%b err=%b we=%b want 0010 0 0",
                            bus.resp, bus.err, bus.mem_we);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, ADDR_W'(16 * i + 1), 16'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if ({bus.grant, bus.mem_re, bus.mem_addr} !== {oh(order[k]), 1'b1, ADDR_W'(16 * order[k] + 1)}) begin
                bad++; $display("FAIL rr_grant%0d: got grant=%b re=%b addr=%h want %b 1 %h",
                                k, bus.grant, bus.mem_re, bus.mem_addr, oh(order[k]), ADDR_W'(16 * order[k] + 1));
            end
            bus.mem_resp = 1'b1;
            tick();
            bus.mem_resp = 1'b0;
            total++;
            if ({bus.resp, bus.err} !== {oh(order[k]), 1'b0}) begin
                bad++; $display("FAIL rr_resp%0d: got resp=%b err=%b want %b 0", k, bus.resp, bus.err, oh(order[k]));
            end
            tick();
            total++;
            if ({bus.grant, bus.resp} !== 8'd0) begin
                bad++; $display("FAIL rr_gap%0d: got grant=%b resp=%b want 0", k, bus.grant, bus.resp);
            end
            if (k == 4) clear_inputs();
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        clear_inputs();
        set_req(3, 1'b1, 1'b0, 14'h3FFF, 16'h0);
        bus.mem_rdata = 8'hFF;
        tick();
        n = 0;
        while (bus.mem_re === 1'b1 && n < TIMEOUT + 8) begin
            n++;
            tick();
        end
        total++;
        if (n !== TIMEOUT) begin
            bad++; $display("FAIL timeout_len: got %0d strobe cycles want %0d", n, TIMEOUT);
        end
        total++;
        if ({bus.resp, bus.err, bus.rdata, bus.grant} !== {4'b1000, 1'b1, 8'h00, 4'b1000}) begin
            bad++; $display("FAIL timeout_resp: got resp=%b err=%b rdata=%h grant=%b want 1000 1 00 1000",
                            bus.resp, bus.err, bus.rdata, bus.grant);
        end
        clear_inputs();
        tick();
        set_req(0, 1'b1, 1'b0, 14'h0042, 16'h0);
        tick();
        total++;
        if ({bus.grant, bus.mem_re, bus.mem_addr} !== {4'b0001, 1'b1, 14'h0042}) begin
            bad++; $display("FAIL timeout_next: got grant=%b re=%b addr=%h want 0001 1 0042",
                            bus.grant, bus.mem_re, bus.mem_addr);
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 8'h3C;
        tick();
        total++;
        if ({bus.resp, bus.err, bus.rdata} !== {4'b0001, 1'b0, 8'h3C}) begin
            bad++; $display("FAIL timeout_next_resp: got resp=%b err=%b rdata=%h want 0001 0 3c",
                            bus.resp, bus.err, bus.rdata);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_illegal();
        clear_inputs();
        set_req(0, 1'b1, 1'b1, 14'h0001, 16'h0);
        tick();
        total++;
        if ({bus.grant, bus.resp, bus.err, bus.mem_re, bus.mem_we} !== {4'b0001, 4'b0001, 3'b100}) begin
            bad++; $display("FAIL illegal_both: got grant=%b resp=%b err=%b re=%b we=%b want 0001 0001 1 0 0",
                            bus.grant, bus.resp, bus.err, bus.mem_re, bus.mem_we);
        end
        clear_inputs();
        tick();
        total++;
        if ({bus.grant, bus.resp} !== 8'd0) begin
            bad++; $display("FAIL illegal_idle: got grant=%b resp=%b want 0", bus.grant, bus.resp);
        end
        set_req(2, 1'b0, 1'b0, 14'h0002, 16'h0);
        tick();
        total++;
        if ({bus.grant, bus.resp, bus.err, bus.mem_re, bus.mem_we} !== {4'b0100, 4'b0100, 3'b100}) begin
            bad++; $display("FAIL illegal_none: got grant=%b resp=%b err=%b re=%b we=%b want 0100 0100 1 0 0",
                            bus.grant, bus.resp, bus.err, bus.mem_re, bus.mem_we);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        set_req(1, 1'b1, 1'b0, 14'h0777, 16'h0);
        tick();
        total++;
        if ({bus.grant, bus.mem_re} !== {4'b0010, 1'b1}) begin
            bad++; $display("FAIL rstmid_access: got grant=%b re=%b want 0010 1", bus.grant, bus.mem_re);
        end
        reset_n = 1'b0;
        tick();
        total++;
        if ({bus.grant, bus.resp, bus.mem_re} !== 9'd0) begin
            bad++; $display("FAIL rstmid_abort: got grant=%b resp=%b re=%b want 0",
                            bus.grant, bus.resp, bus.mem_re);
        end
        reset_n = 1'b1;
        clear_inputs();
        bus.mem_resp = 1'b1;
        tick();
        bus.mem_resp = 1'b0;
        total++;
        if ({bus.grant, bus.resp} !== 8'd0) begin
            bad++; $display("FAIL rstmid_noresp: got grant=%b resp=%b want 0", bus.grant, bus.resp);
        end
        set_req(0, 1'b1, 1'b0, 14'h0010, 16'h0);
        set_req(3, 1'b1, 1'b0, 14'h0030, 16'h0);
        tick();
        total++;
        if (bus.grant !== 4'b0001) begin
            bad++; $display("FAIL rstmid_ptr: got grant=%b want 0001", bus.grant);
        end
        bus.mem_resp = 1'b1;
        tick();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_random(input int ncyc);
        logic [NUM_REQ-1:0] pend;
        int                 waits [NUM_REQ];
        int                 phase, owner, lat, acc, grants, k;
        logic               exp_rd, exp_wr;
        logic [ADDR_W-1:0]  exp_addr;
        logic [WDATA_W-1:0] exp_wdata;
        logic [RDATA_W-1:0] exp_rdata;
        do_reset();
        pend = '0;
        for (int i = 0; i < NUM_REQ; i++) waits[i] = 0;
        phase = 0; owner = 0; lat = 0; acc = 0; grants = 0;
        exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            // phase describes the cycle before the edge just taken: 0 idle, 1 access, 2 resp
            case (phase)
                0: begin
                    owner = pick_model(bus.cs, mptr);
                    if (owner < 0) begin
                        owner = 0;
                        total++;
                        if ({bus.grant, bus.resp, bus.mem_re, bus.mem_we} !== 10'd0) begin
                            bad++; $display("FAIL rnd_idle: got grant=%b resp=%b re=%b we=%b want 0",
                                            bus.grant, bus.resp, bus.mem_re, bus.mem_we);
                        end
                    end else begin
                        grants++;
                        for (int i = 0; i < NUM_REQ; i++)
                            if (i != owner && pend[i] && bus.cs[i]) waits[i]++;
                        waits[owner] = 0;
                        exp_rd    = bus.read_req[owner];
                        exp_wr    = bus.write_req[owner];
                        exp_addr  = bus.addr[owner*ADDR_W +: ADDR_W];
                        exp_wdata = bus.wdata[owner*WDATA_W +: WDATA_W];
                        total++;
                        if (bus.grant !== oh(owner)) begin
                            bad++; $display("FAIL rnd_grant: got %b want %b", bus.grant, oh(owner));
                        end
                        k = 0;
                        for (int i = 0; i < NUM_REQ; i++) if (waits[i] > k) k = waits[i];
                        total++;
                        if (k > NUM_REQ - 1) begin
                            bad++; $display("FAIL rnd_fair: got wait of %0d grants want <= %0d", k, NUM_REQ - 1);
                        end
                        if (exp_rd ^ exp_wr) begin
                            total++;
                            if ({bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.resp} !==
                                {exp_rd, exp_wr, exp_addr, exp_wdata, 4'b0000}) begin
                                bad++; $display("FAIL rnd_cmd: got re=%b we=%b addr=%h wdata=%h resp=%b want %b %b %h %h 0000",
                                                bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.resp,
                                                exp_rd, exp_wr, exp_addr, exp_wdata);
                            end
                            phase = 1; acc = 0; lat = $urandom_range(0, 4);
                        end else begin
                            total++;
                            if ({bus.resp, bus.err, bus.mem_re, bus.mem_we} !== {oh(owner), 3'b100}) begin
                                bad++; $display("FAIL rnd_illegal: got resp=%b err=%b re=%b we=%b want %b 1 0 0",
                                                bus.resp, bus.err, bus.mem_re, bus.mem_we, oh(owner));
                            end
                            phase = 2; pend[owner] = 1'b0;
                        end
                    end
                end
                1: begin
                    total++;
                    if (bus.mem_resp) begin
                        if ({bus.resp, bus.err, bus.rdata, bus.grant, bus.mem_re, bus.mem_we} !==
                            {oh(owner), 1'b0, exp_rdata, oh(owner), 2'b00}) begin
                            bad++; $display("FAIL rnd_resp: got resp=%b err=%b rdata=%h grant=%b re=%b we=%b want %b 0 %h %b 0 0",
                                            bus.resp, bus.err, bus.rdata, bus.grant, bus.mem_re, bus.mem_we,
                                            oh(owner), exp_rdata, oh(owner));
                        end
                        phase = 2; pend[owner] = 1'b0;
                    end else begin
                        if ({bus.grant, bus.resp, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
                            {oh(owner), 4'b0000, exp_rd, exp_wr, exp_addr, exp_wdata}) begin
                            bad++; $display("FAIL rnd_hold: got grant=%b resp=%b re=%b we=%b addr=%h wdata=%h want %b 0000 %b %b %h %h",
                                            bus.grant, bus.resp, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                                            oh(owner), exp_rd, exp_wr, exp_addr, exp_wdata);
                        end
                    end
                end
                default: begin
                    total++;
                    if ({bus.grant, bus.resp} !== 8'd0) begin
                        bad++; $display("FAIL rnd_gap: got grant=%b resp=%b want 0", bus.grant, bus.resp);
                    end
                    mptr  = (owner + 1) % NUM_REQ;
                    phase = 0;
                end
            endcase

            // Memory side: answer the live access after lat cycles, else stray pulses.
            bus.mem_resp = 1'b0;
            if (phase == 1) begin
                if (acc == lat) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = RDATA_W'($urandom);
                    exp_rdata     = bus.mem_rdata;
                end
                acc++;
            end else if ($urandom_range(0, 5) == 0) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = RDATA_W'($urandom);
            end

            for (int i = 0; i < NUM_REQ; i++) begin
                if (phase == 1 && i == owner) begin
                    bus.addr[i*ADDR_W +: ADDR_W]    = ADDR_W'($urandom);
                    bus.wdata[i*WDATA_W +: WDATA_W] = WDATA_W'($urandom);
                    bus.read_req[i]                 = 1'($urandom);
                    bus.write_req[i]                = 1'($urandom);
                    if ($urandom_range(0, 7) == 0) bus.cs[i] = 1'b0;
                end else if (!pend[i]) begin
                    bus.cs[i] = 1'b0;
                    waits[i]  = 0;
                    if ($urandom_range(0, 2) == 0) begin
                        k = $urandom_range(0, 9);
                        pend[i] = 1'b1;
                        set_req(i, (k < 5) || (k == 9), (k >= 5 && k < 9) || (k == 9),
                                ADDR_W'($urandom), WDATA_W'($urandom));
                        if (k == 9 && $urandom_range(0, 1) == 0) begin
                            bus.read_req[i]  = 1'b0;
                            bus.write_req[i] = 1'b0;
                        end
                    end
                end
            end
        end
        total++;
        if (grants < ncyc / 10) begin
            bad++; $display("FAIL rnd_progress: got %0d grants want >= %0d", grants, ncyc / 10);
        end
        clear_inputs();
        repeat (8) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got simulation still running want finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_random(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
